// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO: start, DATA_BITS data (LSB first),
// optional parity, STOP_BITS stop bits; queued frames are sent back-to-back.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              ovalid,
    output logic                              oready,
    input  logic [DATA_BITS-1:0]              inputData,
    output logic                              outScreen,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int DW   = $clog2(CLK_DIV);
    localparam int MAXB = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BW   = $clog2(MAXB);

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    state_t               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;

    logic                 push;
    logic                 pop;
    logic                 tick;
    logic [DATA_BITS-1:0] head;

    assign oready     = (count_q < DEPTH);
    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;
    assign outScreen  = tx_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tx_d     = 1'b1;
        pop      = 1'b0;
        push     = ovalid && oready;
        head     = mem_q[rd_ptr_q];
        tick     = (div_q == DIV_LAST);

        unique case (state_q)
            IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    div_d   = '0;
                    state_d = DATA;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    div_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            PAR: begin
                if (tick) begin
                    div_d   = '0;
                    state_d = STOP;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    div_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Latch the word and its parity at pop so later pushes cannot touch it
        if (pop) begin
            shift_d  = head;
            par_d    = (PARITY == 1) ? ~^head : ^head;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            mem_d[wr_ptr_q] = inputData;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PAR:     tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: four uart_tx_fifo variants, expected frames queued at push
// time and checked cycle by cycle on the TX line by per-instance monitors.
module tb_uart_tx_fifo;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        bit          b2b;
    } frame_t;

    logic       clk = 1'b0;
    logic       rn   [4];
    logic       ov   [4];
    logic [7:0] din  [4];
    logic       rdy  [4];
    logic       line [4];
    logic       bz   [4];
    logic [2:0] cnt  [4];

    int cyc          = 0;
    int tests_run    = 0;
    int tests_failed = 0;

    frame_t q0[$];
    frame_t q1[$];
    frame_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset_n(rn[0]), .ovalid(ov[0]), .oready(rdy[0]),
        .inputData(din[0]), .outScreen(line[0]), .busy(bz[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .reset_n(rn[1]), .ovalid(ov[1]), .oready(rdy[1]),
        .inputData(din[1]), .outScreen(line[1]), .busy(bz[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .reset_n(rn[2]), .ovalid(ov[2]), .oready(rdy[2]),
        .inputData(din[2][4:0]), .outScreen(line[2]), .busy(bz[2]), .fifo_count(cnt[2]));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .reset_n(rn[3]), .ovalid(ov[3]), .oready(rdy[3]),
        .inputData(din[3]), .outScreen(line[3]), .busy(bz[3]), .fifo_count(cnt[3]));

    task automatic chk(input string nm, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qput(input int id, input logic [15:0] b, input int n, input bit g);
        frame_t f;
        f.bits  = b;
        f.nbits = n;
        f.b2b   = g;
        case (id)
            0:       q0.push_back(f);
            1:       q1.push_back(f);
            default: q2.push_back(f);
        endcase
    endtask

    task automatic qpop(input int id, output frame_t f);
        case (id)
            0:       f = q0.pop_front();
            1:       f = q1.pop_front();
            default: f = q2.pop_front();
        endcase
    endtask

    task automatic mon(input int id, input int cdiv);
        frame_t      f;
        int          last_end;
        int          nfr;
        bit          bad;
        logic [15:0] obs;
        last_end = -1;
        nfr = 0;
        forever begin
            @(negedge clk);
            if (line[id] !== 1'b0) continue;
            if (qsize(id) == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_frame dut%0d: line low with no word queued", id);
                while (line[id] === 1'b0) @(negedge clk);
                continue;
            end
            qpop(id, f);
            if (f.b2b) chk($sformatf("gap dut%0d frame%0d", id, nfr), cyc, last_end);
            bad = 1'b0;
            obs = '0;
            for (int k = 0; k < f.nbits * cdiv; k++) begin
                if (k > 0) @(negedge clk);
                if (line[id] !== f.bits[k / cdiv]) bad = 1'b1;
                if (k % cdiv == cdiv / 2) obs[k / cdiv] = line[id];
            end
            last_end = cyc + 1;
            tests_run++;
            if (bad) begin
                tests_failed++;
                $display("FAIL frame dut%0d frame%0d: line bits %0h expected %0h",
                         id, nfr, obs, f.bits);
            end
            nfr++;
        end
    endtask

    task automatic wait_busy(input int id, input int max, output int n);
        n = 0;
        while (bz[id] === 1'b1 && n < max) begin
            n++;
            @(negedge clk);
        end
        if (n >= max) chk($sformatf("busy_timeout dut%0d", id), n, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bexp [5];
        int          cexp [5];
        int          n;
        int          s0;
        int          k;
        int          bad;

        bexp = '{16'h602, 16'h604, 16'h406, 16'h608, 16'h40A};
        cexp = '{1, 1, 2, 3, 4};

        for (int i = 0; i < 4; i++) begin
            rn[i]  = 1'b0;
            ov[i]  = 1'b0;
            din[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_line dut%0d", i), int'(line[i]), 1);
            chk($sformatf("rst_ready dut%0d", i), int'(rdy[i]), 1);
            chk($sformatf("rst_busy dut%0d", i), int'(bz[i]), 0);
            chk($sformatf("rst_count dut%0d", i), int'(cnt[i]), 0);
            rn[i] = 1'b1;
        end
        fork
            mon(0, 4);
            mon(1, 4);
            mon(2, 4);
        join_none
        repeat (2) @(negedge clk);

        // single 8E1 frame
        qput(0, 16'h54A, 11, 1'b0);
        ov[0]  = 1'b1;
        din[0] = 8'hA5;
        @(negedge clk);
        ov[0]  = 1'b0;
        din[0] = 8'h3C;
        chk("a_count_push", int'(cnt[0]), 1);
        chk("a_busy_pre", int'(bz[0]), 0);
        chk("a_line_pre", int'(line[0]), 1);
        @(negedge clk);
        chk("a_busy_rise", int'(bz[0]), 1);
        chk("a_line_fall", int'(line[0]), 0);
        chk("a_count_pop", int'(cnt[0]), 0);
        wait_busy(0, 200, n);
        chk("a_frame_len", n, 44);
        repeat (3) @(negedge clk);

        // five-word burst, refused sixth, refill after first pop
        s0 = 0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("b_ready_w%0d", i), int'(rdy[0]), 1);
            qput(0, bexp[i], 11, i > 0);
            ov[0]  = 1'b1;
            din[0] = 8'(i + 1);
            @(negedge clk);
            chk($sformatf("b_count_w%0d", i), int'(cnt[0]), cexp[i]);
            if (i == 1) s0 = cyc;
        end
        din[0] = 8'h06;
        chk("b_full_ready", int'(rdy[0]), 0);
        k = 0;
        while (rdy[0] !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("b_ready_at_pop", cyc - s0, 44);
        chk("b_pop_count", int'(cnt[0]), 3);
        chk("b_pop_line", int'(line[0]), 0);
        qput(0, 16'h40C, 11, 1'b1);
        @(negedge clk);
        ov[0]  = 1'b0;
        din[0] = 8'hFF;
        chk("b_refill_count", int'(cnt[0]), 4);
        chk("b_refill_ready", int'(rdy[0]), 0);
        wait_busy(0, 400, n);
        chk("b_burst_len", cyc - s0, 264);
        chk("b_end_count", int'(cnt[0]), 0);

        // 8O2, two frames back-to-back
        qput(1, 16'hC0E, 12, 1'b0);
        ov[1]  = 1'b1;
        din[1] = 8'h07;
        @(negedge clk);
        qput(1, 16'hE06, 12, 1'b1);
        din[1] = 8'h03;
        @(negedge clk);
        ov[1] = 1'b0;
        chk("c_busy_rise", int'(bz[1]), 1);
        chk("c_line_fall", int'(line[1]), 0);
        chk("c_count", int'(cnt[1]), 1);
        wait_busy(1, 300, n);
        chk("c_len", n, 96);

        // 5N1, upper input bits carry garbage
        qput(2, 16'h07E, 7, 1'b0);
        ov[2]  = 1'b1;
        din[2] = 8'hFF;
        @(negedge clk);
        qput(2, 16'h054, 7, 1'b1);
        din[2] = 8'hEA;
        @(negedge clk);
        ov[2] = 1'b0;
        chk("d_busy_rise", int'(bz[2]), 1);
        wait_busy(2, 300, n);
        chk("d_len", n, 56);

        // reset mid-frame with three words queued
        for (int i = 0; i < 4; i++) begin
            ov[3]  = 1'b1;
            din[3] = 8'(8'h11 * (i + 1));
            @(negedge clk);
        end
        ov[3] = 1'b0;
        chk("e_queued", int'(cnt[3]), 3);
        repeat (10) @(negedge clk);
        chk("e_busy_mid", int'(bz[3]), 1);
        rn[3] = 1'b0;
        @(negedge clk);
        rn[3] = 1'b1;
        chk("e_rst_line", int'(line[3]), 1);
        chk("e_rst_busy", int'(bz[3]), 0);
        chk("e_rst_count", int'(cnt[3]), 0);
        chk("e_rst_ready", int'(rdy[3]), 1);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (line[3] !== 1'b1 || bz[3] !== 1'b0) bad++;
        end
        chk("e_no_frame_after_reset", bad, 0);

        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("queue_drained dut%0d", i), qsize(i), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
